// File: rtl/mips_ni_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mips_ni_ctrl
//  Description : Traffic sequencer between a pipelined MIPS core and its
//                network interface (NI).
//                  TX : sends issued from EX are queued in a small FIFO
//                       (payload + destination) and drained to the NI with a
//                       valid/ready handshake. A full FIFO stalls the core.
//                  RX : one NI word at a time is captured, held until the
//                       core is ready, and delivered to the register-file
//                       write port with a single-cycle strobe.
//  Ports       :
//    clk, rst                    clock / synchronous active-high reset
//    current_node                address of this node
//    proc_valid_E, to_ni,
//    dest_add_E                  send request from EX stage
//    proc_ready_in_E             core can take an RX word this cycle
//    stall_F                     core must hold (send refused, FIFO full)
//    ni_tx_valid/data/dest/ready TX handshake towards the NI
//    ni_rx_valid/data/ready      RX handshake from the NI
//    wd_NI, data_valid, mips_ni  RX word, pending flag, write strobe
//    tx_count                    TX FIFO occupancy
//    err_self                    sticky flag: a send to ourselves was dropped
//  Revision    : 1.0  initial release
// ============================================================================
module mips_ni_ctrl #(
    parameter int DATA_W = 32,
    parameter int NODE_W = 2,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NODE_W-1:0]          current_node,
    input  logic                       proc_valid_E,
    input  logic [DATA_W-1:0]          to_ni,
    input  logic [NODE_W-1:0]          dest_add_E,
    input  logic                       proc_ready_in_E,
    output logic                       stall_F,
    output logic                       ni_tx_valid,
    output logic [DATA_W-1:0]          ni_tx_data,
    output logic [NODE_W-1:0]          ni_tx_dest,
    input  logic                       ni_tx_ready,
    input  logic                       ni_rx_valid,
    input  logic [DATA_W-1:0]          ni_rx_data,
    output logic                       ni_rx_ready,
    output logic [DATA_W-1:0]          wd_NI,
    output logic                       data_valid,
    output logic                       mips_ni,
    output logic [$clog2(DEPTH):0]     tx_count,
    output logic                       err_self
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = AW + 1;
    localparam int ENT_W = NODE_W + DATA_W;

    localparam logic [CW-1:0] C_FULL_COUNT = CW'(DEPTH);

    // ------------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------------
    logic [ENT_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_err_self;

    logic w_full;
    logic w_empty;
    logic w_self_send;
    logic w_remote_send;
    logic w_push;
    logic w_pop;

    assign w_full        = (r_count == C_FULL_COUNT);
    assign w_empty       = (r_count == '0);
    assign w_self_send   = proc_valid_E && (dest_add_E == current_node);
    assign w_remote_send = proc_valid_E && (dest_add_E != current_node);

    // Full is evaluated on the pre-edge occupancy, so a pop in the same cycle
    // does not open a slot for the push; the core simply re-presents next cycle.
    assign w_push = w_remote_send && !w_full;
    assign w_pop  = !w_empty && ni_tx_ready;

    assign stall_F = w_remote_send && w_full;

    // Storage needs no reset: occupancy and pointers define what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {dest_add_E, to_ni};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            // DEPTH is a power of two, so natural pointer overflow wraps.
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_self <= 1'b0;
        end else if (w_self_send) begin
            r_err_self <= 1'b1;
        end
    end

    // First-word fall-through: the head entry is driven straight from storage.
    // It cannot change while valid and not popped, because only a pop moves
    // the read pointer and a push never targets the head slot of a non-empty
    // FIFO.
    assign ni_tx_valid              = !w_empty;
    assign {ni_tx_dest, ni_tx_data} = r_mem[r_rd_ptr];
    assign tx_count                 = r_count;
    assign err_self                 = r_err_self;

    // ------------------------------------------------------------------------
    // RX sequencer: capture -> hold until core ready -> one-cycle deliver
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        RX_IDLE    = 2'd0,
        RX_HOLD    = 2'd1,
        RX_DELIVER = 2'd2
    } rx_state_t;

    rx_state_t         r_rx_state;
    rx_state_t         w_rx_next;
    logic [DATA_W-1:0] r_wd_ni;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_state <= RX_IDLE;
        end else begin
            r_rx_state <= w_rx_next;
        end
    end

    always_comb begin
        w_rx_next = r_rx_state;
        case (r_rx_state)
            RX_IDLE: begin
                if (ni_rx_valid) begin
                    w_rx_next = RX_HOLD;
                end
            end
            RX_HOLD: begin
                if (proc_ready_in_E) begin
                    w_rx_next = RX_DELIVER;
                end
            end
            RX_DELIVER: begin
                w_rx_next = RX_IDLE;
            end
            default: begin
                w_rx_next = RX_IDLE;
            end
        endcase
    end

    // The captured word persists after delivery until the next capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wd_ni <= '0;
        end else if ((r_rx_state == RX_IDLE) && ni_rx_valid) begin
            r_wd_ni <= ni_rx_data;
        end
    end

    // Outputs decode the state register only, so they change solely on edges.
    assign ni_rx_ready = (r_rx_state == RX_IDLE);
    assign data_valid  = (r_rx_state == RX_HOLD) || (r_rx_state == RX_DELIVER);
    assign mips_ni     = (r_rx_state == RX_DELIVER);
    assign wd_NI       = r_wd_ni;

endmodule
`default_nettype wire

// File: tb/tb_mips_ni_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mips_ni_ctrl
//  Description : Self-checking bench for mips_ni_ctrl. Directed scenarios
//                followed by randomized traffic, all compared every cycle
//                against a queue-based reference model of the controller.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mips_ni_ctrl;

    localparam int DATA_W = 32;
    localparam int NODE_W = 2;
    localparam int DEPTH  = 4;
    localparam int CW     = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic [NODE_W-1:0] current_node;
    logic              proc_valid_E;
    logic [DATA_W-1:0] to_ni;
    logic [NODE_W-1:0] dest_add_E;
    logic              proc_ready_in_E;
    logic              stall_F;
    logic              ni_tx_valid;
    logic [DATA_W-1:0] ni_tx_data;
    logic [NODE_W-1:0] ni_tx_dest;
    logic              ni_tx_ready;
    logic              ni_rx_valid;
    logic [DATA_W-1:0] ni_rx_data;
    logic              ni_rx_ready;
    logic [DATA_W-1:0] wd_NI;
    logic              data_valid;
    logic              mips_ni;
    logic [CW-1:0]     tx_count;
    logic              err_self;

    always #5 clk = ~clk;

    mips_ni_ctrl #(.DATA_W(DATA_W), .NODE_W(NODE_W), .DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst             (rst),
        .current_node    (current_node),
        .proc_valid_E    (proc_valid_E),
        .to_ni           (to_ni),
        .dest_add_E      (dest_add_E),
        .proc_ready_in_E (proc_ready_in_E),
        .stall_F         (stall_F),
        .ni_tx_valid     (ni_tx_valid),
        .ni_tx_data      (ni_tx_data),
        .ni_tx_dest      (ni_tx_dest),
        .ni_tx_ready     (ni_tx_ready),
        .ni_rx_valid     (ni_rx_valid),
        .ni_rx_data      (ni_rx_data),
        .ni_rx_ready     (ni_rx_ready),
        .wd_NI           (wd_NI),
        .data_valid      (data_valid),
        .mips_ni         (mips_ni),
        .tx_count        (tx_count),
        .err_self        (err_self)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: a plain queue of pending sends plus the RX word status.
    logic [NODE_W+DATA_W-1:0] m_q[$];
    logic [DATA_W-1:0]        m_word;
    bit                       m_have;     // a word is held for the core
    bit                       m_strobe;   // the held word is being written now
    bit                       m_err;
    bit                       m_known = 1'b0;

    logic [DATA_W-1:0]        tx_log[$];  // words the NI side actually took
    int                       strobes;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: comparisons of combinational outputs before the edge,
    // model advance at the edge, registered outputs just after it.
    task automatic cycle();
        bit full_pre;
        bit pop;
        bit push;
        @(negedge clk);
        full_pre = (m_q.size() == DEPTH);
        if (m_known) begin
            chk("stall_F", stall_F,
                proc_valid_E && (dest_add_E != current_node) && full_pre);
            chk("tx_valid", ni_tx_valid, m_q.size() != 0);
            if (m_q.size() != 0) begin
                chk("tx_head", {ni_tx_dest, ni_tx_data}, m_q[0]);
            end
        end
        if (ni_tx_valid && ni_tx_ready) begin
            tx_log.push_back(ni_tx_data);
        end
        @(posedge clk);
        if (rst) begin
            m_q.delete();
            m_have   = 0;
            m_strobe = 0;
            m_word   = '0;
            m_err    = 0;
            m_known  = 1;
        end else begin
            pop  = (m_q.size() != 0) && ni_tx_ready;
            push = proc_valid_E && (dest_add_E != current_node) && !full_pre;
            if (pop) void'(m_q.pop_front());
            if (push) m_q.push_back({dest_add_E, to_ni});
            if (proc_valid_E && (dest_add_E == current_node)) m_err = 1;
            if (m_strobe) begin
                m_strobe = 0;
                m_have   = 0;
            end else if (m_have) begin
                if (proc_ready_in_E) m_strobe = 1;
            end else if (ni_rx_valid) begin
                m_have = 1;
                m_word = ni_rx_data;
            end
        end
        #1;
        if (mips_ni) strobes++;
        if (m_known) begin
            chk("tx_count", tx_count, m_q.size());
            chk("rx_ready", ni_rx_ready, !m_have);
            chk("data_valid", data_valid, m_have);
            chk("mips_ni", mips_ni, m_strobe);
            chk("wd_NI", wd_NI, m_word);
            chk("err_self", err_self, m_err);
        end
    endtask

    task automatic idle_inputs();
        proc_valid_E    = 0;
        to_ni           = '0;
        dest_add_E      = '0;
        proc_ready_in_E = 0;
        ni_tx_ready     = 0;
        ni_rx_valid     = 0;
        ni_rx_data      = '0;
    endtask

    initial begin
        logic [DATA_W-1:0] exp_w;
        rst          = 1;
        current_node = '0;
        idle_inputs();

        // T1: reset
        cycle();
        cycle();
        rst = 0;
        chk("t1_count", tx_count, 0);
        chk("t1_tx_valid", ni_tx_valid, 0);
        chk("t1_rx_ready", ni_rx_ready, 1);
        chk("t1_mips_ni", mips_ni, 0);
        chk("t1_err", err_self, 0);
        chk("t1_stall", stall_F, 0);

        // T2: fill and stall with NI back-pressured
        tx_log.delete();
        current_node = 2'd0;
        dest_add_E   = 2'd1;
        for (int i = 0; i < 5; i++) begin
            proc_valid_E = 1;
            to_ni        = 32'hA0 + i;
            if (i == 4) begin
                #1;
                chk("t2_stall_5th", stall_F, 1);
            end
            cycle();
        end
        chk("t2_count_full", tx_count, 4);
        ni_tx_ready = 1;               // pop frees a slot only after this edge
        #1;
        chk("t2_stall_pop_cycle", stall_F, 1);
        cycle();
        chk("t2_stall_released", stall_F, 0);
        cycle();                       // 0xA4 accepted now
        proc_valid_E = 0;
        for (int i = 0; i < 5; i++) cycle();
        chk("t2_log_size", tx_log.size(), 5);
        for (int i = 0; i < 5; i++) begin
            exp_w = 32'hA0 + i;
            if (i < tx_log.size()) chk("t2_order", tx_log[i], exp_w);
        end

        // T3: streaming through the pointer wrap
        tx_log.delete();
        ni_tx_ready = 1;
        for (int i = 0; i < 10; i++) begin
            proc_valid_E = 1;
            to_ni        = 32'h100 + i;
            cycle();
            chk("t3_count_le1", tx_count <= 1, 1);
        end
        proc_valid_E = 0;
        cycle();
        cycle();
        chk("t3_log_size", tx_log.size(), 10);
        for (int i = 0; i < 10; i++) begin
            exp_w = 32'h100 + i;
            if (i < tx_log.size()) chk("t3_order", tx_log[i], exp_w);
        end

        // T4: self-send is dropped and flagged
        current_node = 2'd2;
        dest_add_E   = 2'd2;
        to_ni        = 32'h55;
        proc_valid_E = 1;
        #1;
        chk("t4_no_stall", stall_F, 0);
        cycle();
        proc_valid_E = 0;
        chk("t4_err", err_self, 1);
        chk("t4_no_push", tx_count, 0);
        cycle();
        chk("t4_err_sticky", err_self, 1);

        // T5: RX capture, hold for 3 cycles, single delivery strobe
        strobes     = 0;
        ni_rx_valid = 1;
        ni_rx_data  = 32'hDEADBEEF;
        cycle();
        ni_rx_valid = 0;
        for (int i = 0; i < 3; i++) begin
            chk("t5_dv_hold", data_valid, 1);
            chk("t5_rdy_hold", ni_rx_ready, 0);
            cycle();
        end
        proc_ready_in_E = 1;
        cycle();
        proc_ready_in_E = 0;
        chk("t5_strobe", mips_ni, 1);
        chk("t5_word", wd_NI, 32'hDEADBEEF);
        cycle();
        chk("t5_dv_clear", data_valid, 0);
        chk("t5_one_pulse", strobes, 1);
        chk("t5_word_kept", wd_NI, 32'hDEADBEEF);

        // T6: reset in the middle of activity
        ni_tx_ready  = 0;
        current_node = 2'd0;
        dest_add_E   = 2'd3;
        proc_valid_E = 1;
        to_ni        = 32'h11;
        cycle();
        to_ni        = 32'h22;
        ni_rx_valid  = 1;
        ni_rx_data   = 32'h1234;
        cycle();
        proc_valid_E = 0;
        ni_rx_valid  = 0;
        chk("t6_queued", tx_count, 2);
        chk("t6_hold", data_valid, 1);
        rst = 1;
        cycle();
        rst = 0;
        chk("t6_count", tx_count, 0);
        chk("t6_dv", data_valid, 0);
        chk("t6_rx_idle", ni_rx_ready, 1);
        chk("t6_wd", wd_NI, 0);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            rst             = ($urandom_range(63) == 0);
            if ($urandom_range(99) == 0) current_node = NODE_W'($urandom);
            proc_valid_E    = $urandom_range(1);
            to_ni           = $urandom;
            dest_add_E      = NODE_W'($urandom);
            proc_ready_in_E = ($urandom_range(2) != 0);
            ni_tx_ready     = ($urandom_range(2) == 0);
            ni_rx_valid     = $urandom_range(1);
            ni_rx_data      = $urandom;
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
